// File: rtl/front_panel_control.sv
// SSEM front-panel run/stop/step controller: synchronises and debounces the
// panel inputs and sequences the STOPPED/ACTIVE/HALTED machine that gates the CPU clock.

module fpc_debounce #(
   parameter logic [31:0] CYCLES = 32'd500000
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic raw,
   output logic level
);
   logic [1:0]  sync;
   logic [31:0] count;

   // The counter only advances while the synchronised input disagrees with the
   // debounced level, so any glitch shorter than CYCLES is discarded.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         sync  <= '0;
         level <= 1'b0;
         count <= '0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == level) begin
            count <= '0;
         end else if (count == CYCLES - 32'd1) begin
            level <= sync[1];
            count <= '0;
         end else begin
            count <= count + 32'd1;
         end
      end
   end
endmodule

module front_panel_control #(
   parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic run_button,
   input  logic stop_button,
   input  logic step_button,
   input  logic step_mode_switch,
   input  logic halt,
   output logic stop,
   output logic single_step,
   output logic single_stepping,
   output logic running_led,
   output logic halted_led,
   output logic halt_ack
);
   localparam int NUM_IN = 4;
   localparam int RUN    = 0;
   localparam int STP    = 1;
   localparam int STEP   = 2;
   localparam int MODE   = 3;

   typedef enum logic [1:0] {STOPPED, ACTIVE, HALTED} state_t;

   state_t            state;
   logic [NUM_IN-1:0] raw_in;
   logic [NUM_IN-1:0] deb;
   logic [NUM_IN-1:0] deb_dly;
   logic [NUM_IN-1:0] press;

   assign raw_in = {step_mode_switch, step_button, stop_button, run_button};

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
      fpc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk_in  (clk_in),
         .reset_n (reset_n),
         .raw     (raw_in[gi]),
         .level   (deb[gi])
      );
   end

   // Rising edge of the debounced level: one event per press, none on release.
   assign press = deb & ~deb_dly;

   // Outputs are assigned alongside each state change so they stay registered
   // and line up with the state they describe.
   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state           <= STOPPED;
         deb_dly         <= '0;
         stop            <= 1'b1;
         single_step     <= 1'b0;
         single_stepping <= 1'b0;
         running_led     <= 1'b0;
         halted_led      <= 1'b0;
         halt_ack        <= 1'b0;
      end else begin
         deb_dly         <= deb;
         single_stepping <= deb[MODE];
         single_step     <= 1'b0;
         halt_ack        <= 1'b0;
         case (state)
            STOPPED: begin
               if (press[RUN]) begin
                  state       <= ACTIVE;
                  stop        <= 1'b0;
                  running_led <= 1'b1;
               end
            end
            ACTIVE: begin
               // halt outranks a stop press, which outranks a step press
               if (halt) begin
                  state       <= HALTED;
                  stop        <= 1'b1;
                  running_led <= 1'b0;
                  halted_led  <= 1'b1;
               end else if (press[STP]) begin
                  state       <= STOPPED;
                  stop        <= 1'b1;
                  running_led <= 1'b0;
               end else if (press[STEP] && single_stepping) begin
                  single_step <= 1'b1;
               end
            end
            HALTED: begin
               if (press[RUN]) begin
                  state      <= STOPPED;
                  halted_led <= 1'b0;
                  halt_ack   <= 1'b1;
               end
            end
            default: begin
               state       <= STOPPED;
               stop        <= 1'b1;
               running_led <= 1'b0;
               halted_led  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_front_panel_control.sv
// Bench for front_panel_control with a short debounce: each expected output
// change is queued with its due cycle and matched by an independent monitor.

module tb_front_panel_control;
   logic clk_in = 1'b0;
   logic reset_n = 1'b0;
   logic run_button = 1'b0;
   logic stop_button = 1'b0;
   logic step_button = 1'b0;
   logic step_mode_switch = 1'b0;
   logic halt = 1'b0;
   logic stop, single_step, single_stepping, running_led, halted_led, halt_ack;

   front_panel_control #(.DEBOUNCE_CYCLES(32'd4)) dut (
      .clk_in           (clk_in),
      .reset_n          (reset_n),
      .run_button       (run_button),
      .stop_button      (stop_button),
      .step_button      (step_button),
      .step_mode_switch (step_mode_switch),
      .halt             (halt),
      .stop             (stop),
      .single_step      (single_step),
      .single_stepping  (single_stepping),
      .running_led      (running_led),
      .halted_led       (halted_led),
      .halt_ack         (halt_ack)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int         cyc;
      logic [5:0] v;
   } exp_t;

   exp_t       sb[$];
   exp_t       mexp;
   int         cyc = 0;
   int         t0 = 0;
   int         checks = 0;
   int         failures = 0;
   bit         mon_en = 1'b0;
   logic [5:0] prev;
   logic [5:0] obs;

   // {stop, single_step, single_stepping, running_led, halted_led, halt_ack}
   assign obs = {stop, single_step, single_stepping, running_led, halted_led, halt_ack};

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (mon_en && obs !== prev) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change cyc=%0d got=%b was=%b", cyc, obs, prev);
         end else begin
            mexp = sb.pop_front();
            if (obs !== mexp.v || cyc != mexp.cyc) begin
               failures++;
               $display("FAIL out_change got=%b at cyc %0d, want=%b at cyc %0d",
                        obs, cyc, mexp.v, mexp.cyc);
            end
         end
         prev = obs;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic expect_out(input int off, input logic [5:0] v);
      exp_t e;
      e.cyc = t0 + off;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic release_all();
      tick(10);
      run_button  = 1'b0;
      stop_button = 1'b0;
      step_button = 1'b0;
      tick(12);
   endtask

   initial begin
      tick(3);
      checks++;
      if (obs !== 6'b100000) begin
         failures++;
         $display("FAIL reset_state got=%b want=%b", obs, 6'b100000);
      end
      reset_n = 1'b1;
      prev    = obs;
      mon_en  = 1'b1;
      tick(10);

      // short glitches never reach the debounced level
      for (int l = 1; l <= 3; l++) begin
         run_button = 1'b1;
         tick(l);
         run_button = 1'b0;
         tick(10);
      end
      tick(15);

      // run then stop, D+3 cycles after driving each input
      run_button = 1'b1;  t0 = cyc; expect_out(7, 6'b000100); release_all();
      stop_button = 1'b1; t0 = cyc; expect_out(7, 6'b100000); release_all();

      step_mode_switch = 1'b1; t0 = cyc; expect_out(7, 6'b101000); tick(12);
      run_button = 1'b1; t0 = cyc; expect_out(7, 6'b001100); release_all();
      for (int i = 0; i < 3; i++) begin
         step_button = 1'b1; t0 = cyc;
         expect_out(7, 6'b011100);
         expect_out(8, 6'b001100);
         release_all();
      end
      step_mode_switch = 1'b0; t0 = cyc; expect_out(7, 6'b000100); tick(12);
      for (int i = 0; i < 3; i++) begin
         step_button = 1'b1;
         release_all();
      end

      // halt, ignored stop, acknowledge, re-halt while halt held
      halt = 1'b1; t0 = cyc; expect_out(1, 6'b100010); tick(5);
      stop_button = 1'b1; release_all();
      run_button = 1'b1; t0 = cyc;
      expect_out(7, 6'b100001); expect_out(8, 6'b100000); release_all();
      run_button = 1'b1; t0 = cyc;
      expect_out(7, 6'b000100); expect_out(8, 6'b100010); release_all();
      halt = 1'b0;
      run_button = 1'b1; t0 = cyc;
      expect_out(7, 6'b100001); expect_out(8, 6'b100000); release_all();
      run_button = 1'b1; t0 = cyc; expect_out(7, 6'b000100); release_all();

      // simultaneous events in step mode
      step_mode_switch = 1'b1; t0 = cyc; expect_out(7, 6'b001100); tick(12);
      step_button = 1'b1; stop_button = 1'b1; t0 = cyc;
      expect_out(7, 6'b101000); release_all();
      run_button = 1'b1; t0 = cyc; expect_out(7, 6'b001100); release_all();
      step_button = 1'b1; t0 = cyc;
      expect_out(7, 6'b101010);
      tick(6);
      halt = 1'b1;
      release_all();
      halt = 1'b0;
      run_button = 1'b1; t0 = cyc;
      expect_out(7, 6'b101001); expect_out(8, 6'b101000); release_all();
      run_button = 1'b1; t0 = cyc; expect_out(7, 6'b001100); release_all();

      // reset lands on the edge the step pulse is due
      step_button = 1'b1; t0 = cyc; expect_out(7, 6'b100000);
      tick(6);
      reset_n = 1'b0;
      step_button = 1'b0;
      tick(2);
      reset_n = 1'b1; t0 = cyc; expect_out(7, 6'b101000);
      tick(15);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL pending_changes got=%0d want=0 next_due=%0d", sb.size(), sb[0].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/front_panel_control.md
# front_panel_control

Front-panel run/stop/step controller for the SSEM. Synchronises and debounces the raw panel buttons and the step-mode switch, and runs a run/stop/halt state machine. Drives the `stop`, `single_step` and `single_stepping` inputs of the clock generator directly upstream of it. Also latches a halt raised by the CPU's stop instruction until the operator acknowledges it.

## Interface
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive stable cycles required before a debounced input changes; legal range 1 to 2^32-1.

- `clk_in`  input  1  system clock, same clock as the clock generator
- `reset_n`  input  1  synchronous, active-low reset
- `run_button`  input  1  raw asynchronous pushbutton, active high
- `stop_button`  input  1  raw asynchronous pushbutton, active high
- `step_button`  input  1  raw asynchronous pushbutton, active high
- `step_mode_switch`  input  1  raw asynchronous toggle: 1 = single step, 0 = free run
- `halt`  input  1  level from the CPU, synchronous to `clk_in`: stop instruction executed
- `stop`  output  1  hold the CPU clock low; to the clock generator
- `single_step`  output  1  one-cycle step pulse; to the clock generator
- `single_stepping`  output  1  debounced step mode; to the clock generator
- `running_led`  output  1  high in ACTIVE
- `halted_led`  output  1  high in HALTED
- `halt_ack`  output  1  one-cycle pulse when the operator clears a halt

## Operation
- Each of the four raw inputs passes through a 2-flop synchroniser, then a debouncer.
- Debouncer: a 32-bit counter runs while the synchronised value differs from the debounced value.
  - It resets to 0 on any cycle they match.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced value takes the synchronised value and the counter clears.
- Press event: debounced value high while its one-cycle-delayed copy is low. Each button gives exactly one event per debounced press. Releases give no event.
- `single_stepping` is the registered debounced `step_mode_switch`, independent of FSM state.
- FSM states and transitions, in priority order within a cycle:
  - STOPPED (reset state): run press -> ACTIVE. `halt` is ignored. Stop and step presses are ignored.
  - ACTIVE:
    - `halt` high -> HALTED.
    - Otherwise a stop press -> STOPPED.
    - Otherwise a step press with `single_stepping`=1 -> `single_step` pulses high for one cycle and the state stays ACTIVE.
    - A step press with `single_stepping`=0 is ignored.
  - HALTED: run press -> STOPPED with `halt_ack` high for that one cycle. Everything else is ignored.
- Outputs by state:
  - `stop` = 1 in STOPPED and HALTED, 0 in ACTIVE.
  - `running_led` = (state==ACTIVE).
  - `halted_led` = (state==HALTED).
- Simultaneous events:
  - `halt` beats stop and step presses: no `single_step` pulse.
  - A stop press beats a step press: no pulse.
  - Run and stop presses together in STOPPED: run wins, because stop is ignored there.
- Changing the mode switch while ACTIVE changes only `single_stepping`; the state is unaffected.
- If `halt` is still high when the state returns to ACTIVE, the FSM re-enters HALTED on the next cycle.

## Timing
- All outputs are registered and change only on the rising edge of `clk_in`.
- Reset (`reset_n`=0 at a rising edge):
  - State STOPPED.
  - `stop`=1; `single_step`, `single_stepping`, `running_led`, `halted_led` and `halt_ack` all 0.
  - Synchronisers, debounced values, delayed copies and counters all 0.
- Reset mid-operation behaves the same: any pending `single_step`/`halt_ack` pulse is dropped and partial debounce counts are discarded.
- Button latency: raw input captured by the synchroniser at edge k and held stable:
  - Debounced value changes at edge k+1+D.
  - FSM and outputs respond at edge k+2+D (D = DEBOUNCE_CYCLES).
- `single_stepping` follows the switch with the same D+2 latency.
- `halt` latency: `halt` high at edge n while ACTIVE gives `stop`=1 and `halted_led`=1 after edge n.
- `single_step` is exactly one `clk_in` cycle wide and starts low. This satisfies the clock generator's rising-edge detector.
- A glitch shorter than D cycles at the synchroniser output produces no debounced change and no event.

## Test plan
- Reset, then idle with D=4 -> `stop`=1 and all other outputs 0 for 50 cycles; glitches of 1-3 cycles on `run_button` cause no change.
- `run_button` held high from edge k, D=4 -> `stop` falls and `running_led` rises at edge k+6; a following `stop_button` press -> `stop`=1 after the same 6-cycle latency.
- Switch=1, ACTIVE, three separate step presses -> exactly three one-cycle `single_step` pulses. With switch=0, the same presses -> no pulses.
- ACTIVE, assert `halt` -> `stop`=1 and `halted_led`=1 next edge. A stop press while halted changes nothing. A run press -> STOPPED with one `halt_ack` pulse. A second run press with `halt` still high -> ACTIVE for one cycle, then HALTED.
- Step and stop presses debounced on the same cycle in ACTIVE with switch=1 -> STOPPED, no `single_step` pulse. Step press coinciding with `halt` -> HALTED, no pulse.
- `reset_n` low during the cycle a `single_step` pulse is due -> no pulse, `stop`=1, state STOPPED.
